ldst_cbz_encoder: RTL
=====================

Name: ldst_cbz_encoder

Overview:
- Inverse of the immediate sign-extension path: packs LDUR, STUR and CBZ fields into 32-bit LEGv8 instruction words.
- Range-checks each full-width signed immediate and truncates it into the instruction's immediate field.
- Encoded words go into a small output FIFO with valid/ready handshakes on both sides.
- Feeds the instruction-memory loader and the self-checking bench: sign-extending an emitted word must return the original immediate.

Parameters:
- N, 64, width of the signed immediate input (matches datapath width).
- DEPTH, 2, output FIFO entries; power of two, 2..16.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  encoder can accept a request this cycle.
- op  in  2  00 LDUR, 01 STUR, 10 CBZ, 11 illegal.
- rt  in  5  Rt field.
- rn  in  5  Rn field; ignored for CBZ.
- imm  in  N  signed immediate: byte offset for LDUR/STUR, word offset for CBZ.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer takes head.
- instr  out  32  encoded word at FIFO head.
- out_err  out  1  head entry failed encoding.
- err_count  out  8  saturating count of errored requests.

Behaviour:
- Handshakes:
  - Accept when in_valid && in_ready.
  - Pop when out_valid && out_ready.
  - in_ready = !full, registered-state based. No accept while full, even if a pop occurs that cycle.
- Latency:
  - A word accepted at edge t is visible on instr/out_valid after edge t (1 cycle).
  - instr, out_err and out_valid are driven from FIFO storage only. No combinational input-to-output path.
- Encoding, combinational before the FIFO write:
  - LDUR: {11'b111_1100_0010, imm[8:0], 2'b00, rn, rt}.
  - STUR: {11'b111_1100_0000, imm[8:0], 2'b00, rn, rt}.
  - CBZ: {8'b1011_0100, imm[18:0], rt}.
- Range rules:
  - LDUR/STUR legal imm: -256..255, i.e. bits [N-1:8] all equal imm[8].
  - CBZ legal imm: -262144..262143, i.e. bits [N-1:18] all equal imm[18].
- Error entries:
  - Trigger: op=11 or imm out of range.
  - Entry stored with instr=32'h0000_0000 and err=1.
  - err_count increments on accept and saturates at 255.
- FIFO:
  - Circular buffer with read/write pointers plus an occupancy count 0..DEPTH. Pointers wrap modulo DEPTH.
  - full = count==DEPTH; empty = count==0; out_valid = !empty.
  - Simultaneous push and pop when not full and not empty: count unchanged, both pointers advance.
  - Push into an empty FIFO with out_ready=1: the word is not popped in the same cycle (1-cycle latency holds).
- Reset (asynchronous; any cycle, including mid-transfer):
  - Pointers, count and err_count = 0; out_valid = 0; instr = 0; out_err = 0; in_ready = 1 from the first edge after release.
  - In-flight entries are discarded.
- Stability: while out_valid=1 and out_ready=0, instr and out_err must hold stable.

Optional Feature:
- Macro: LDST_CBZ_ENCODER_CLAMP_EN.
- Defined:
  - Out-of-range immediates saturate to the field limit (-256/255 or -262144/262143) and are encoded normally with err=0.
  - Only op=11 produces err=1 and increments err_count.
- Undefined: range errors behave as stated in Behaviour.

Test Plan:
- Legal encodes: LDUR rt=1 rn=2 imm=-8, then STUR rt=3 rn=4 imm=255, then CBZ rt=5 imm=-1 -> f85f8041, f80ff083, b4ffffe5, each with out_err=0. Sign-extending each word returns the original imm.
- Range boundaries:
  - LDUR imm=-256 -> f8500000, err=0.
  - LDUR imm=256 -> 00000000, err=1, err_count=1.
  - With the CLAMP macro, LDUR imm=256 -> f84ff000, err=0.
- Backpressure: out_ready=0, push 3 requests with DEPTH=2 -> in_ready drops after the 2nd accept, the 3rd is held. Raise out_ready -> words emerge in order, nothing lost or duplicated, instr stable while stalled.
- Streaming: in_valid=1 and out_ready=1 for 20 cycles -> one word per cycle after 1-cycle latency, count never exceeds 1.
- Illegal op: op=11 sent 300 times -> every entry has err=1, instr=0; err_count saturates at 255.
- Reset mid-operation: FIFO holding 2 entries, assert reset between edges -> out_valid=0 and err_count=0 immediately. After release in_ready=1 and no stale words appear.

Source files
------------

// File: rtl/ldst_cbz_encoder_if.sv
// Request/response bundle for ldst_cbz_encoder: request fields with valid/ready in,
// encoded-word FIFO head with valid/ready out, plus the saturating error counter.
interface ldst_cbz_encoder_if #(
  parameter int N = 64
);
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [4:0]   rt;
  logic [4:0]   rn;
  logic [N-1:0] imm;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  instr;
  logic         out_err;
  logic [7:0]   err_count;

  modport master (
    output in_valid, op, rt, rn, imm, out_ready,
    input  in_ready, out_valid, instr, out_err, err_count
  );

  modport slave (
    input  in_valid, op, rt, rn, imm, out_ready,
    output in_ready, out_valid, instr, out_err, err_count
  );
endinterface

// File: rtl/ldst_cbz_encoder.sv
// Packs LDUR/STUR/CBZ fields into LEGv8 words with immediate range checking, queued in a DEPTH-entry FIFO.
// Latency: 1 cycle from accept to FIFO head. Backpressure: in_ready = !full; no accept while full, even on a same-cycle pop.
// Define LDST_CBZ_ENCODER_CLAMP_EN to saturate out-of-range immediates instead of flagging them as errors.
module ldst_cbz_encoder #(
  parameter int N     = 64,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  ldst_cbz_encoder_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

`ifdef LDST_CBZ_ENCODER_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  localparam logic [1:0] OP_LDUR = 2'b00;
  localparam logic [1:0] OP_STUR = 2'b01;
  localparam logic [1:0] OP_CBZ  = 2'b10;

  typedef struct packed {
    logic        err;
    logic [31:0] instr;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [7:0]    err_cnt;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          ls_ok;
  logic          cb_ok;
  logic [8:0]    imm9;
  logic [18:0]   imm19;
  entry_t        enc;

  // An immediate fits its field when every bit above the field's sign bit copies it.
  assign ls_ok = (bus.imm[N-1:8]  == {(N-8){bus.imm[8]}});
  assign cb_ok = (bus.imm[N-1:18] == {(N-18){bus.imm[18]}});

  // Saturation picks the limit on the side of the true sign.
  assign imm9  = (CLAMP && !ls_ok) ? (bus.imm[N-1] ? 9'h100 : 9'h0ff)
                                   : bus.imm[8:0];
  assign imm19 = (CLAMP && !cb_ok) ? (bus.imm[N-1] ? 19'h40000 : 19'h3ffff)
                                   : bus.imm[18:0];

  always_comb begin
    enc = '0;
    case (bus.op)
      OP_LDUR: begin
        enc.err   = !CLAMP && !ls_ok;
        enc.instr = {11'b111_1100_0010, imm9, 2'b00, bus.rn, bus.rt};
      end
      OP_STUR: begin
        enc.err   = !CLAMP && !ls_ok;
        enc.instr = {11'b111_1100_0000, imm9, 2'b00, bus.rn, bus.rt};
      end
      OP_CBZ: begin
        enc.err   = !CLAMP && !cb_ok;
        enc.instr = {8'b1011_0100, imm19, bus.rt};
      end
      default: enc.err = 1'b1;
    endcase
    if (enc.err) enc.instr = '0;
  end

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign push  = bus.in_valid && !full;
  assign pop   = !empty && bus.out_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= enc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      err_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (enc.err && (err_cnt != 8'hff)) err_cnt <= err_cnt + 8'd1;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Head outputs are forced low while empty so reset and drained states read as zero.
  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.instr     = empty ? 32'h0 : mem[rd_ptr].instr;
  assign bus.out_err   = !empty && mem[rd_ptr].err;
  assign bus.err_count = err_cnt;
endmodule
